// File: rtl/gbfact_pkg.sv
// Shared defaults and grant encoding for the GBFACT RAM controller.
package gbfact_pkg;

  localparam int SRAM_DEPTH_BIT_DEF = 6;
  localparam int SRAM_WIDTH_DEF     = 28;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/gbfact_resp_fifo.sv
// Two-entry in-order response FIFO; a pop frees a slot for a push in the same cycle.
module gbfact_resp_fifo #(
  parameter int SRAM_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [SRAM_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [SRAM_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  logic [SRAM_WIDTH-1:0] r_mem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_cnt;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign w_do_pop  = i_pop && (r_cnt != 2'd0);
  assign w_do_push = i_push && ((r_cnt != 2'd2) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // When full, the slot being written is the head being popped this cycle.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_data;
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_cnt;

endmodule

// File: rtl/gbfact_ram_ctrl.sv
// Arbitrates writes and reads onto a single-port RAM with a 2-credit read response path.
// Optional macro GBFACT_RR_ARB_EN selects round-robin conflict arbitration instead of write priority.
module gbfact_ram_ctrl
  import gbfact_pkg::*;
#(
  parameter int SRAM_DEPTH_BIT = SRAM_DEPTH_BIT_DEF,
  parameter int SRAM_WIDTH     = SRAM_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [SRAM_DEPTH_BIT-1:0] wr_addr,
  input  logic [SRAM_WIDTH-1:0]     wr_data,
  input  logic                      rd_req_valid,
  output logic                      rd_req_ready,
  input  logic [SRAM_DEPTH_BIT-1:0] rd_addr,
  output logic                      rd_data_valid,
  input  logic                      rd_data_ready,
  output logic [SRAM_WIDTH-1:0]     rd_data,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_w,
  output logic [SRAM_DEPTH_BIT-1:0] ram_addr_r,
  output logic                      ram_write_en,
  output logic                      ram_read_en,
  output logic [SRAM_WIDTH-1:0]     ram_data_in,
  input  logic [SRAM_WIDTH-1:0]     ram_data_out
);

  logic       r_inflight;
  logic [1:0] w_fifo_cnt;
  logic [1:0] w_credits;
  logic       w_pop;
  logic       w_credit_ok;
  logic       w_wr_wins;
  logic       w_rd_grant;

  assign w_pop       = rd_data_valid && rd_data_ready;
  assign w_credits   = {1'b0, r_inflight} + w_fifo_cnt;
  assign w_credit_ok = (w_credits < 2'd2) || w_pop;

`ifdef GBFACT_RR_ARB_EN
  // Holds the side that wins the next conflict; flips after each conflict.
  grant_e r_last_grant;
  logic   w_conflict;

  assign w_wr_wins  = (r_last_grant == GRANT_WR);
  assign w_conflict = wr_valid && rd_req_valid && w_credit_ok && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_last_grant <= GRANT_WR;
    else if (w_conflict) r_last_grant <= w_wr_wins ? GRANT_RD : GRANT_WR;
  end
`else
  assign w_wr_wins = 1'b1;
`endif

  assign rd_req_ready = rst_n && w_credit_ok && !(wr_valid && w_wr_wins);
  assign w_rd_grant   = rd_req_valid && rd_req_ready;
  assign wr_ready     = rst_n && !w_rd_grant;

  assign ram_write_en = wr_valid && wr_ready;
  assign ram_addr_w   = wr_addr;
  assign ram_data_in  = wr_data;
  assign ram_read_en  = w_rd_grant;
  assign ram_addr_r   = rd_addr;

  // Reset drops the in-flight flag, so RAM data from an interrupted read is never captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight <= 1'b0;
    else        r_inflight <= w_rd_grant;
  end

  gbfact_resp_fifo #(
    .SRAM_WIDTH(SRAM_WIDTH)
  ) u_resp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_push_data(ram_data_out),
    .i_pop      (w_pop),
    .o_valid    (rd_data_valid),
    .o_data     (rd_data),
    .o_count    (w_fifo_cnt)
  );

endmodule

// File: tb/tb_gbfact_ram_ctrl.sv
// Directed bench for gbfact_ram_ctrl with a behavioural single-port RAM (registered read).
module tb_gbfact_ram_ctrl;

  localparam int AW = 6;
  localparam int DW = 28;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_data_valid, rd_data_ready;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr_w, ram_addr_r;
  logic          ram_write_en, ram_read_en;
  logic [DW-1:0] ram_data_in, ram_data_out;

  logic [DW-1:0] mem [64];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gbfact_ram_ctrl #(
    .SRAM_DEPTH_BIT(AW),
    .SRAM_WIDTH    (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_data_valid(rd_data_valid),
    .rd_data_ready(rd_data_ready),
    .rd_data      (rd_data),
    .ram_addr_w   (ram_addr_w),
    .ram_addr_r   (ram_addr_r),
    .ram_write_en (ram_write_en),
    .ram_read_en  (ram_read_en),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    ram_data_out = '0;
  end

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
    if (ram_read_en)  ram_data_out    <= mem[ram_addr_r];
  end

  always @(posedge clk) begin
    assert (!(ram_write_en && ram_read_en))
    else begin
      $display("FAIL port_excl: write_en=%0b read_en=%0b required not both high", ram_write_en, ram_read_en);
      miscompares++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      miscompares++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0; rd_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; rd_req_valid = 1'b0;
    #1;
    cyc();
    wr_valid = 1'b0;
  endtask

  int acc;
  int wcnt;
  int rcnt;

  initial begin
    rst_n = 1'b0; wr_valid = 1'b1; rd_req_valid = 1'b1; rd_data_ready = 1'b1;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    #12;
    chk("rst_rd_data_valid", rd_data_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_write_en", ram_write_en, 0);
    chk("rst_read_en", ram_read_en, 0);
    idle();
    @(negedge clk); rst_n = 1'b1;
    cyc();
    chk("post_rst_wr_ready", wr_ready, 1);
    chk("post_rst_rd_req_ready", rd_req_ready, 1);

    // Write then read address 5
    wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 28'hABCDEF0;
    #1;
    chk("w5_write_en", ram_write_en, 1);
    chk("w5_addr_w", ram_addr_w, 5);
    chk("w5_data_in", ram_data_in, 28'hABCDEF0);
    cyc();
    wr_valid = 1'b0; rd_req_valid = 1'b1; rd_addr = 6'd5;
    #1;
    chk("r5_req_ready", rd_req_ready, 1);
    chk("r5_read_en", ram_read_en, 1);
    chk("r5_addr_r", ram_addr_r, 5);
    cyc();
    rd_req_valid = 1'b0;
    #1;
    chk("r5_valid_at_1", rd_data_valid, 0);
    cyc();
    chk("r5_valid_at_2", rd_data_valid, 1);
    chk("r5_data", rd_data, 28'hABCDEF0);
    cyc();
    chk("r5_drained", rd_data_valid, 0);

    // Simultaneous requests for 4 cycles
    wcnt = 0; rcnt = 0;
    wr_valid = 1'b1; rd_req_valid = 1'b1; wr_addr = 6'd10; wr_data = 28'h1111111; rd_addr = 6'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      wcnt += int'(ram_write_en);
      rcnt += int'(ram_read_en);
      cyc();
    end
    idle();
`ifdef GBFACT_RR_ARB_EN
    chk("conflict_writes", wcnt, 2);
    chk("conflict_reads", rcnt, 2);
`else
    chk("conflict_writes", wcnt, 4);
    chk("conflict_reads", rcnt, 0);
`endif
    repeat (4) cyc();

    // Credit limit with back-pressured response
    for (int i = 1; i <= 5; i++) do_write(AW'(i), DW'(32'h100 + i));
    rd_data_ready = 1'b0; acc = 0;
    for (int i = 1; i <= 5; i++) begin
      rd_req_valid = 1'b1; rd_addr = AW'(i);
      #1;
      if (rd_req_ready) acc++;
      cyc();
    end
    chk("credit_accepted", acc, 2);
    #1;
    chk("credit_ready_low", rd_req_ready, 0);
    cyc();
    chk("credit_ready_still_low", rd_req_ready, 0);
    rd_req_valid = 1'b0; rd_data_ready = 1'b1;
    #1;
    chk("drain0_valid", rd_data_valid, 1);
    chk("drain0_data", rd_data, 28'h101);
    cyc();
    chk("drain1_valid", rd_data_valid, 1);
    chk("drain1_data", rd_data, 28'h102);
    cyc();
    chk("drain_empty", rd_data_valid, 0);

    // Top address, write then immediate read
    do_write(6'd63, 28'h1234567);
    do_write(6'd63, 28'hFEDCBA9);
    rd_req_valid = 1'b1; rd_addr = 6'd63;
    #1;
    chk("a63_read_en", ram_read_en, 1);
    cyc();
    rd_req_valid = 1'b0;
    cyc();
    chk("a63_valid", rd_data_valid, 1);
    chk("a63_data", rd_data, 28'hFEDCBA9);
    cyc();

    // Reset with a read in flight
    rd_req_valid = 1'b1; rd_addr = 6'd5;
    #1;
    cyc();
    rd_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", rd_data_valid, 0);
    chk("rst_mid_rd_data", rd_data, 0);
    cyc();
    @(negedge clk); rst_n = 1'b1;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (rd_data_valid) acc++;
    end
    chk("rst_no_stale_valid", acc, 0);
    rd_data_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_req_valid = 1'b1; rd_addr = AW'(3 + i);
      #1;
      chk("rst_credit_free", rd_req_ready, 1);
      cyc();
    end
    rd_req_valid = 1'b0; rd_data_ready = 1'b1;
    #1;
    chk("rst_after_data0", rd_data, 28'h103);
    cyc();
    chk("rst_after_data1", rd_data, 28'h104);
    cyc();
    chk("rst_after_empty", rd_data_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/gbfact_ram_ctrl.md
GBFACT_RAM_CTRL -- requirements
Module: gbfact_ram_ctrl

Interface
REQ-001 SHALL have parameter SRAM_DEPTH_BIT, default 6, address width.
REQ-002 SHALL have parameter SRAM_WIDTH, default 28, data width.
REQ-003 SHALL have port clk, input, 1, the single clock for the whole block.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have write-request ports wr_valid (in, 1), wr_ready (out, 1), wr_addr (in, SRAM_DEPTH_BIT) and wr_data (in, SRAM_WIDTH).
REQ-006 SHALL have read-request ports rd_req_valid (in, 1), rd_req_ready (out, 1) and rd_addr (in, SRAM_DEPTH_BIT).
REQ-007 SHALL have read-response ports rd_data_valid (out, 1), rd_data_ready (in, 1) and rd_data (out, SRAM_WIDTH).
REQ-008 SHALL have RAM-side ports ram_addr_w and ram_addr_r (out, SRAM_DEPTH_BIT), ram_write_en and ram_read_en (out, 1), ram_data_in (out, SRAM_WIDTH) and ram_data_out (in, SRAM_WIDTH), matching the single-port GBFACT RAM wrapper.

Function
REQ-009 SHALL assert at most one of ram_write_en and ram_read_en in any cycle, because the RAM is single-port.
REQ-010 SHALL complete a write on wr_valid&&wr_ready, driving ram_write_en=1, ram_addr_w=wr_addr and ram_data_in=wr_data combinationally in that same cycle.
REQ-011 SHALL issue a read on rd_req_valid&&rd_req_ready, driving ram_read_en=1 and ram_addr_r=rd_addr combinationally.
REQ-012 SHALL treat ram_data_out as valid exactly one cycle after ram_read_en, and SHALL capture it into the response FIFO on that cycle.
REQ-013 SHALL implement the response FIFO as 2 entries, in order, with a skid-free valid/ready output.
REQ-014 SHALL keep a credit count equal to in-flight reads plus FIFO occupancy, range 0..2.
REQ-015 SHALL deassert rd_req_ready whenever the credit count is 2, counting a same-cycle FIFO pop as freeing a credit.
REQ-016 Default arbitration: when both requests are valid, the write wins, rd_req_ready=0 and wr_ready=1.
REQ-017 SHALL give wr_ready=1 whenever no read is being granted in that cycle, since writes never stall otherwise.
REQ-018 SHALL preserve issue order for ordering hazards: a read issued in the cycle after a write to the same address returns the new data.
REQ-019 SHALL drive rd_data from the FIFO head and assert rd_data_valid while the FIFO is non-empty.
REQ-020 On simultaneous FIFO push and pop with the FIFO full, the pop SHALL occur first and the push SHALL be accepted.
REQ-021 FIFO pointers SHALL be 1 bit each and wrap modulo 2.

Reset
REQ-022 While rst_n=0: FIFO empty, credit count 0, in-flight flag 0, rd_data_valid=0, ram_read_en=0, ram_write_en=0, rd_data=0.
REQ-023 A read in flight when reset is asserted SHALL be discarded, and its RAM data SHALL be ignored after release.
REQ-024 Outputs SHALL be valid from the first clk edge after rst_n deassertion, with wr_ready=1 and rd_req_ready=1.

Configuration
REQ-025 Macro GBFACT_RR_ARB_EN: when defined, conflicts SHALL be resolved round-robin via a 1-bit last-grant register (reset value: write), alternating the winner on each conflict.
REQ-026 Without GBFACT_RR_ARB_EN, the fixed write priority of REQ-016 SHALL apply and the last-grant register SHALL not exist.

Structure
REQ-027 A shared package gbfact_pkg SHALL hold the SRAM_DEPTH_BIT/SRAM_WIDTH defaults and the GRANT_WR/GRANT_RD encoding constants.
REQ-028 The response FIFO SHALL be one sub-module, gbfact_resp_fifo (depth 2, parameter SRAM_WIDTH).

Verification
REQ-029 Write addr 5 data 0xABCDEF0, then read addr 5 -> rd_data=0xABCDEF0, with rd_data_valid 2 cycles after the read handshake.
REQ-030 wr_valid and rd_req_valid both high for 4 cycles -> default: 4 writes, 0 reads; with GBFACT_RR_ARB_EN: grants alternate W,R,W,R.
REQ-031 rd_data_ready=0 and 5 reads requested -> exactly 2 accepted and rd_req_ready=0 from then on; raising rd_data_ready drains the 2 results in order.
REQ-032 Write addr 63 then read addr 63 in the next cycle -> the new data is returned, checking the top-address boundary.
REQ-033 Assert rst_n=0 one cycle after a read handshake -> no rd_data_valid after release, and credits return to 0.
REQ-034 Throughout all scenarios, an assertion SHALL check that ram_write_en and ram_read_en are never both high.
